comparator: RTL and testbench
=============================

COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port clk  input  1  rising-edge clock for all registered outputs.
REQ-003 Port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 Port A  input  WIDTH  first operand.
REQ-005 Port B  input  WIDTH  second operand.
REQ-006 Port signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
REQ-007 Port in_valid  input  1  qualifies A/B/signed_mode for the registered path.
REQ-008 Port Amenor  output  1  combinational "A less than B" flag.
REQ-009 Port lt_q  output  1  registered A<B.
REQ-010 Port eq_q  output  1  registered A==B.
REQ-011 Port gt_q  output  1  registered A>B.
REQ-012 Port out_valid  output  1  registered copy of in_valid; qualifies lt_q/eq_q/gt_q.
REQ-013 Ports SHALL be declared in the order clk, rst, A, B, signed_mode, in_valid, Amenor, lt_q, eq_q, gt_q, out_valid; instances connect by name.

Function
REQ-014 Amenor SHALL be purely combinational, zero-cycle latency, valid whenever A/B/signed_mode are stable, independent of clk, rst and in_valid.
REQ-015 Amenor SHALL be 1 iff A < B under the mode selected by signed_mode, else 0; A==B gives 0.
REQ-016 Unsigned mode: operands SHALL be treated as 0..2^WIDTH-1 (8'h80 > 8'h7F).
REQ-017 Signed mode: operands SHALL be treated as two's complement (8'h80 = -128 < 8'h7F = +127).
REQ-018 Extremes: all-zeros vs all-ones and equal operands SHALL compare correctly in both modes; no overflow or wrap condition exists.
REQ-019 On each rising clk edge with rst=0 and in_valid=1: lt_q, eq_q, gt_q SHALL load the compare result of the current inputs; exactly one of the three is 1.
REQ-020 On each rising clk edge with rst=0 and in_valid=0: lt_q, eq_q, gt_q SHALL hold; out_valid SHALL load 0.
REQ-021 out_valid SHALL equal in_valid delayed by exactly one clock; registered-path latency is one cycle.
REQ-022 Back-to-back in_valid SHALL give one result per cycle with no bubbles.

Reset
REQ-023 With rst=1 at a rising clk edge: lt_q=0, eq_q=0, gt_q=0, out_valid=0, overriding in_valid.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; first valid result appears one cycle after the first in_valid=1 edge following rst deassertion.
REQ-025 Amenor SHALL be unaffected by rst.

Structure
REQ-026 A shared package SHALL hold the default WIDTH constant and an enumerated/encoded compare-result type (LT, EQ, GT).
REQ-027 Compare SHALL be built from one sub-module, comparator_slice (1-bit magnitude slice: inputs a, b, lt_in, eq_in; outputs lt_out, eq_out), chained MSB-to-LSB WIDTH times by generate.
REQ-028 Signed mode SHALL be realised by inverting the MSB of both operands before the slice chain; no arithmetic subtractor.
REQ-029 gt SHALL be derived as neither lt nor eq; Amenor and lt_q SHALL share the same chain output.

Verification
REQ-030 Unsigned, A=8'hFF, B=8'h00 -> Amenor=0; next edge with in_valid=1: gt_q=1, out_valid=1.
REQ-031 Unsigned sweep: (8'hAF,8'hFF)->1, (8'h00,8'h01)->1, (8'hFD,8'hFF)->1, (8'hDF,8'hF7)->1, (8'h4F,8'h37)->0 on Amenor, each checked 10 ns after input change.
REQ-032 A=8'h80, B=8'h7F -> Amenor=0 with signed_mode=0, Amenor=1 with signed_mode=1.
REQ-033 A=B=8'h00 and A=B=8'hFF in both modes -> Amenor=0; registered eq_q=1, lt_q=gt_q=0.
REQ-034 Stream three valid pairs, drop in_valid one cycle, assert rst mid-stream -> results one cycle late, hold during gap, all registered outputs 0 after reset edge, Amenor continuously correct.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator: default operand width and the
// encoded three-way compare result.
package comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_LT   = 2'd1,
        CMP_EQ   = 2'd2,
        CMP_GT   = 2'd3
    } cmp_res_e;

    // Fold the chain's less-than / equal flags into one result code.
    // Greater-than is whatever is neither less-than nor equal.
    function automatic cmp_res_e cmp_encode(input logic lt, input logic eq);
        cmp_res_e res;
        if (lt) begin
            res = CMP_LT;
        end else if (eq) begin
            res = CMP_EQ;
        end else begin
            res = CMP_GT;
        end
        return res;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One bit of a ripple magnitude comparator. Slices are chained from the MSB
// downwards; the first slice that sees a difference decides the result and
// every lower slice just passes it on.
module comparator_slice (
    input  logic a,
    input  logic b,
    input  logic lt_in,
    input  logic eq_in,
    output logic lt_out,
    output logic eq_out
);

    // Less-than latches once a higher bit decided it, or here if all higher
    // bits matched and this bit has a=0, b=1.
    always_comb begin
        lt_out = lt_in | (eq_in & ~a & b);
        eq_out = eq_in & ~(a ^ b);
    end

endmodule

// File: rtl/comparator.sv
// Magnitude comparator with a combinational A<B flag and a one-cycle
// registered three-way result. Signed compare is done by flipping the sign
// bits before the unsigned slice chain, which maps two's complement order
// onto unsigned order without any subtraction.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    input  logic             in_valid,
    output logic             Amenor,
    output logic             lt_q,
    output logic             eq_q,
    output logic             gt_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_a_adj;
    logic [WIDTH-1:0] w_b_adj;
    logic [WIDTH:0]   w_lt_chain;
    logic [WIDTH:0]   w_eq_chain;
    logic             w_lt;
    logic             w_eq;
    logic             w_gt;
    cmp_res_e         w_res;

    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic             r_valid;

    // Sign-bit flip for two's complement mode; lower bits pass unchanged.
    always_comb begin
        w_a_adj = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
        w_b_adj = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
    end

    // Chain seed: nothing decided yet, all (zero) higher bits equal.
    assign w_lt_chain[0] = 1'b0;
    assign w_eq_chain[0] = 1'b1;

    // Chain position i handles operand bit WIDTH-1-i, so MSB is evaluated first.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        comparator_slice u_slice (
            .a      (w_a_adj[WIDTH-1-i]),
            .b      (w_b_adj[WIDTH-1-i]),
            .lt_in  (w_lt_chain[i]),
            .eq_in  (w_eq_chain[i]),
            .lt_out (w_lt_chain[i+1]),
            .eq_out (w_eq_chain[i+1])
        );
    end

    // Final chain outputs; greater-than is derived, never computed separately.
    always_comb begin
        w_lt  = w_lt_chain[WIDTH];
        w_eq  = w_eq_chain[WIDTH];
        w_gt  = ~w_lt & ~w_eq;
        w_res = cmp_encode(w_lt, w_eq);
    end

    // Combinational flag shares the chain output with the registered path.
    assign Amenor = w_lt;

    // Result register: clears on reset, loads on valid, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                case (w_res)
                    CMP_LT: begin
                        r_lt <= 1'b1;
                        r_eq <= 1'b0;
                        r_gt <= 1'b0;
                    end
                    CMP_EQ: begin
                        r_lt <= 1'b0;
                        r_eq <= 1'b1;
                        r_gt <= 1'b0;
                    end
                    default: begin
                        r_lt <= 1'b0;
                        r_eq <= 1'b0;
                        r_gt <= w_gt;
                    end
                endcase
            end else begin
                r_lt <= r_lt;
                r_eq <= r_eq;
                r_gt <= r_gt;
            end
        end
    end

    assign lt_q      = r_lt;
    assign eq_q      = r_eq;
    assign gt_q      = r_gt;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator (WIDTH=8). Expected registered results
// are queued when a valid pair is driven and popped when out_valid appears.
module tb_comparator;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       signed_mode;
    logic       in_valid;
    logic       Amenor;
    logic       lt_q;
    logic       eq_q;
    logic       gt_q;
    logic       out_valid;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } exp_t;

    exp_t sb_q[$];
    exp_t hold_m;
    int   n_cmp;
    int   n_err;

    comparator #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .A           (A),
        .B           (B),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .Amenor      (Amenor),
        .lt_q        (lt_q),
        .eq_q        (eq_q),
        .gt_q        (gt_q),
        .out_valid   (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic ref_lt(input logic [7:0] a, input logic [7:0] b, input logic sm);
        if (sm) return ($signed(a) < $signed(b));
        else    return (a < b);
    endfunction

    function automatic exp_t ref_res(input logic [7:0] a, input logic [7:0] b, input logic sm);
        exp_t e;
        logic lt;
        logic gt;
        lt = ref_lt(a, b, sm);
        gt = ref_lt(b, a, sm);
        e.lt = lt;
        e.eq = (a == b);
        e.gt = gt;
        return e;
    endfunction

    // One clock of stimulus: check Amenor shortly after the input change,
    // then check the registered outputs just after the edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic v, input logic r, input string tag);
        exp_t e;
        logic exp_ov;
        A = a; B = b; signed_mode = sm; in_valid = v; rst = r;
        #2;
        n_cmp++;
        if (Amenor !== ref_lt(a, b, sm)) begin
            n_err++;
            $display("FAIL %s amenor A=%h B=%h sm=%b: got %b want %b", tag, a, b, sm, Amenor, ref_lt(a, b, sm));
        end
        if (r) sb_q.delete();
        else if (v) sb_q.push_back(ref_res(a, b, sm));
        @(posedge clk);
        #1;
        if (r) hold_m = '0;
        exp_ov = v & ~r;
        n_cmp++;
        if (out_valid !== exp_ov) begin
            n_err++;
            $display("FAIL %s out_valid: got %b want %b", tag, out_valid, exp_ov);
        end
        if (exp_ov) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s scoreboard: got empty queue want one entry", tag);
            end else begin
                e = sb_q.pop_front();
                hold_m = e;
            end
        end
        n_cmp++;
        if ({lt_q, eq_q, gt_q} !== {hold_m.lt, hold_m.eq, hold_m.gt}) begin
            n_err++;
            $display("FAIL %s lt/eq/gt: got %b%b%b want %b%b%b", tag, lt_q, eq_q, gt_q,
                     hold_m.lt, hold_m.eq, hold_m.gt);
        end
    endtask

    task automatic test_reset();
        step(8'h12, 8'h34, 1'b0, 1'b1, 1'b1, "reset");
        step(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, "reset_hold");
    endtask

    task automatic test_ff_vs_00();
        step(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, "ff_vs_00");
        step(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, "00_vs_ff_u");
        step(8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, "00_vs_ff_s");
    endtask

    task automatic test_unsigned_sweep();
        logic [7:0] av [5];
        logic [7:0] bv [5];
        logic       ev [5];
        av = '{8'hAF, 8'h00, 8'hFD, 8'hDF, 8'h4F};
        bv = '{8'hFF, 8'h01, 8'hFF, 8'hF7, 8'h37};
        ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            A = av[i]; B = bv[i]; signed_mode = 1'b0; in_valid = 1'b0; rst = 1'b0;
            #10;
            n_cmp++;
            if (Amenor !== ev[i]) begin
                n_err++;
                $display("FAIL sweep%0d amenor A=%h B=%h: got %b want %b", i, av[i], bv[i], Amenor, ev[i]);
            end
        end
        @(posedge clk);
        #1;
        step(8'h4F, 8'h37, 1'b0, 1'b0, 1'b0, "sweep_idle");
    endtask

    task automatic test_signed_boundary();
        step(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, "80_7f_u");
        step(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, "80_7f_s");
        step(8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, "7f_80_s");
        step(8'hFE, 8'h01, 1'b1, 1'b1, 1'b0, "fe_01_s");
    endtask

    task automatic test_equal_extremes();
        step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "eq00_u");
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "eq00_s");
        step(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, "eqff_u");
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, "eqff_s");
    endtask

    task automatic test_stream_reset();
        step(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, "stream0");
        step(8'h30, 8'h30, 1'b0, 1'b1, 1'b0, "stream1");
        step(8'h90, 8'h20, 1'b1, 1'b1, 1'b0, "stream2");
        step(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, "gap");
        step(8'h55, 8'h44, 1'b0, 1'b1, 1'b0, "stream3");
        step(8'h01, 8'h09, 1'b1, 1'b1, 1'b1, "mid_reset");
        step(8'h01, 8'h09, 1'b1, 1'b0, 1'b0, "post_reset_idle");
        step(8'hC0, 8'h3F, 1'b1, 1'b1, 1'b0, "post_reset_first");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        for (int i = 0; i < 24; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = (i % 6 == 0) ? a : 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            step(a, b, sm, 1'b1, 1'b0, "b2b");
        end
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "b2b_end");
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        hold_m = '0;
        rst = 1'b1;
        A = 8'h00;
        B = 8'h00;
        signed_mode = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_ff_vs_00();
        test_unsigned_sweep();
        test_signed_boundary();
        test_equal_extremes();
        test_stream_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
